// File: rtl/ram_ctrl_pkg.sv
// Shared types for the RAM request controller: request/response payloads
// and the run/drain/halt control states.
package ram_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] addr;
  } rsp_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/ram_req_ctrl_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, show-ahead read port and occupancy
// count. A push into a full FIFO is accepted only when a pop happens in the
// same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, payload only
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ram_req_ctrl.sv
// Request-side controller in front of a 256x8 single-port RAM with a
// one-cycle registered read (data_out/valid_out). Requests are queued and
// issued in order, one per cycle; reads only issue when the response FIFO
// is guaranteed room for them. Optional statistics counters are built when
// RAM_REQ_CTRL_STATS_EN is defined; otherwise wr_count/rd_count read as 0.
module ram_req_ctrl import ram_ctrl_pkg::*; #(
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data_out,
  input  logic              ram_valid_out,
  input  logic              drain,
  output logic              idle,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  localparam int QCW = $clog2(REQ_DEPTH) + 1;
  localparam int RCW = $clog2(RSP_DEPTH) + 1;

  ctrl_state_e      state;
  req_t             req_in;
  req_t             req_head;
  rsp_t             rsp_in;
  rsp_t             rsp_head;
  logic [QCW-1:0]   req_count;
  logic [RCW-1:0]   rsp_count;
  logic             req_full;
  logic             req_empty;
  logic             req_push;
  logic [1:0]       inflight;
  logic [RCW:0]     rsp_occ;
  logic             issue;
  logic             rd_issue;
  logic             capture;
  logic             rsp_pop;
  logic [ADDR_W-1:0] tag_p1;

  assign req_full  = (req_count == QCW'(REQ_DEPTH));
  assign req_empty = (req_count == '0);
  assign req_ready = rst && !req_full && (state == ST_RUN);
  assign req_push  = req_valid && req_ready;
  assign req_in    = '{we: req_we, addr: req_addr, wdata: req_wdata};

  sync_fifo #(.WIDTH($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_push),
    .wdata (req_in),
    .pop   (issue),
    .rdata (req_head),
    .count (req_count)
  );

  // Space check covers both buffered responses and reads still in the RAM,
  // so every issued read is guaranteed a response slot.
  assign rsp_occ  = {1'b0, rsp_count} + (RCW+1)'(inflight);
  assign issue    = !req_empty && (req_head.we || (rsp_occ < (RCW+1)'(RSP_DEPTH)));
  assign rd_issue = issue && !req_head.we;
  assign capture  = ram_valid_out && (inflight != 2'd0);

  // Issue register: at most one RAM command per cycle, in queue order
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_we      <= 1'b0;
      ram_re      <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
    end else begin
      ram_we <= issue && req_head.we;
      ram_re <= rd_issue;
      if (issue) begin
        ram_addr    <= req_head.addr;
        ram_data_in <= req_head.wdata;
      end
    end
  end

  // Reads issued but not yet captured from the RAM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= 2'd0;
    end else begin
      case ({rd_issue, capture})
        2'b10:   inflight <= inflight + 2'd1;
        2'b01:   inflight <= inflight - 2'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Address tag, second stage (ram_addr is the first); lines up with valid_out
  always_ff @(posedge clk) begin
    if (ram_re) tag_p1 <= ram_addr;
  end

  assign rsp_in  = '{rdata: ram_data_out, addr: tag_p1};
  assign rsp_pop = rsp_valid && rsp_ready;

  sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .wdata (rsp_in),
    .pop   (rsp_pop),
    .rdata (rsp_head),
    .count (rsp_count)
  );

  assign rsp_valid = (rsp_count != '0);
  assign rsp_rdata = rsp_valid ? rsp_head.rdata : '0;
  assign rsp_addr  = rsp_valid ? rsp_head.addr  : '0;

  assign idle = req_empty && !rsp_valid && (inflight == 2'd0) && !ram_we && !ram_re;

  // Run/drain/halt control; drain completes once nothing is queued or in the RAM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (drain) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (!drain)
            state <= ST_RUN;
          else if (req_empty && (inflight == 2'd0) && !ram_we && !ram_re)
            state <= ST_HALT;
        end
        ST_HALT:  if (!drain) state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  // Return data with no outstanding read behind it is dropped
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst)
    ram_valid_out |-> (inflight != 2'd0));

`ifdef RAM_REQ_CTRL_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating counts of issued writes and captured reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= 16'd0;
      rd_count <= 16'd0;
    end else begin
      if (issue && req_head.we) wr_count <= sat_inc16(wr_count);
      if (capture)              rd_count <= sat_inc16(rd_count);
    end
  end
`else
  assign wr_count = 16'd0;
  assign rd_count = 16'd0;
`endif

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl with a behavioural 256x8 RAM (one-cycle registered
// read, cleared by reset). Read expectations are queued at handshake time and
// a monitor compares each delivered response against the queue head.
module tb_ram_req_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_rdata, rsp_addr;
  logic [7:0]  ram_data_in, ram_addr, ram_data_out;
  logic        ram_we, ram_re, ram_valid_out;
  logic        drain, idle;
  logic [15:0] wr_count, rd_count;

  int passed = 0;
  int total  = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  ram_req_ctrl #(.REQ_DEPTH(4), .RSP_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_addr      (rsp_addr),
    .ram_data_in   (ram_data_in),
    .ram_we        (ram_we),
    .ram_re        (ram_re),
    .ram_addr      (ram_addr),
    .ram_data_out  (ram_data_out),
    .ram_valid_out (ram_valid_out),
    .drain         (drain),
    .idle          (idle),
    .wr_count      (wr_count),
    .rd_count      (rd_count)
  );

  // RAM model
  logic [7:0] ram_mem [256];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'h00;
      ram_data_out  <= 8'h00;
      ram_valid_out <= 1'b0;
    end else begin
      ram_valid_out <= ram_re;
      if (ram_re) ram_data_out <= ram_mem[ram_addr];
      if (ram_we) ram_mem[ram_addr] <= ram_data_in;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL rsp_unexpected: got addr 0x%0h data 0x%0h, want no response", rsp_addr, rsp_rdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("rsp_addr_data", {rsp_addr, rsp_rdata}, e);
      end
    end
  end

  // Starts and ends on a falling edge; track=1 queues the expected read data.
  task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d, input logic track);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = we ? d : 8'h00;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      $display("FAIL send_timeout: got req_ready=0 for 300 cycles, want 1 (addr 0x%0h)", a);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (!we && track) exp_q.push_back({a, d});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || !idle) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle"}, 16'(idle), 16'd1);
    chk({nm, "_pending"}, 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    rsp_ready = 1'b1; drain = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_req_ready", 16'(req_ready), 16'd0);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_ram_we", 16'(ram_we), 16'd0);
    chk("rst_ram_re", 16'(ram_re), 16'd0);
    chk("rst_ram_addr", 16'(ram_addr), 16'd0);
    chk("rst_ram_data_in", 16'(ram_data_in), 16'd0);
    chk("rst_rsp_rdata", 16'(rsp_rdata), 16'd0);
    chk("rst_rsp_addr", 16'(rsp_addr), 16'd0);
    chk("rst_wr_count", wr_count, 16'd0);
    chk("rst_rd_count", rd_count, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("run_req_ready", 16'(req_ready), 16'd1);
    chk("run_idle", 16'(idle), 16'd1);

    // Write then back-to-back read, 3-cycle read latency
    send(1'b1, 8'h10, 8'hA5, 1'b0);
    send(1'b0, 8'h10, 8'hA5, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("lat_after_e2", 16'(rsp_valid), 16'd0);
    @(negedge clk);
    chk("lat_after_e3", 16'(rsp_valid), 16'd1);
    wait_done("t1");

    // Backpressure: 4 reads buffered, 4 queued, nothing lost
    for (int i = 0; i < 8; i++) send(1'b1, 8'h20 + 8'(i), 8'h50 + 8'(i), 1'b0);
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(1'b0, 8'h20 + 8'(i), 8'h50 + 8'(i), 1'b1);
    repeat (4) @(negedge clk);
    chk("bp_req_ready", 16'(req_ready), 16'd0);
    chk("bp_ram_re", 16'(ram_re), 16'd0);
    chk("bp_rsp_valid", 16'(rsp_valid), 16'd1);
    chk("bp_rsp_addr", 16'(rsp_addr), 16'h20);
    chk("bp_rsp_rdata", 16'(rsp_rdata), 16'h50);
    repeat (3) @(negedge clk);
    chk("bp_rsp_rdata_held", 16'(rsp_rdata), 16'h50);
    rsp_ready = 1'b1;
    wait_done("t2");

    // Address boundaries
    send(1'b1, 8'hFF, 8'h3C, 1'b0);
    send(1'b0, 8'hFF, 8'h3C, 1'b1);
    send(1'b0, 8'h00, 8'h00, 1'b1);
    wait_done("t3");

    // Drain to halt and resume
    send(1'b1, 8'h40, 8'h11, 1'b0);
    send(1'b1, 8'h41, 8'h22, 1'b0);
    send(1'b1, 8'h42, 8'h33, 1'b0);
    drain = 1'b1;
    @(negedge clk);
    chk("drain_req_ready", 16'(req_ready), 16'd0);
    n = 0;
    while (!idle && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("halt_idle", 16'(idle), 16'd1);
    chk("halt_req_ready", 16'(req_ready), 16'd0);
    drain = 1'b0;
    @(negedge clk);
    chk("resume_req_ready", 16'(req_ready), 16'd1);
    send(1'b0, 8'h42, 8'h33, 1'b1);
    send(1'b0, 8'h40, 8'h11, 1'b1);
    wait_done("t4");

    // Reset with reads in flight
    send(1'b0, 8'h10, 8'hA5, 1'b0);
    send(1'b0, 8'h20, 8'h50, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("mid_rst_ram_re", 16'(ram_re), 16'd0);
    chk("mid_rst_ram_addr", 16'(ram_addr), 16'd0);
    chk("mid_rst_req_ready", 16'(req_ready), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_rsp_valid", 16'(rsp_valid), 16'd0);
    send(1'b0, 8'h10, 8'h00, 1'b1);
    wait_done("t5");

    // Statistics since the last reset: 5 writes, 3 reads
    for (int i = 0; i < 5; i++) send(1'b1, 8'h30 + 8'(i), 8'h60 + 8'(i), 1'b0);
    send(1'b0, 8'h30, 8'h60, 1'b1);
    send(1'b0, 8'h34, 8'h64, 1'b1);
    wait_done("t6");
`ifdef RAM_REQ_CTRL_STATS_EN
    chk("wr_count", wr_count, 16'd5);
    chk("rd_count", rd_count, 16'd3);
`else
    chk("wr_count", wr_count, 16'd0);
    chk("rd_count", rd_count, 16'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
